// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing the load-store datapath (ld, st, add, sub, addi, beq, bne).
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
   parameter int MEM_LATENCY = 1,   // 1..15
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             zero,
   output logic             load_ir,
   output logic             load_pc,
   output logic             reset_pc,
   output logic             pc_next_sel,
   output logic             sub,
   output logic             ULA_din2_sel,
   output logic             RF_din_sel,
   output logic             WE_RF,
   output logic             WE_MEM,
   output logic             halt,
`ifdef CTRL_RETIRE_CNT_EN
   output logic [CNT_W-1:0] retired_cnt,
`endif
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_LD   = 3'd0,
      C_ST   = 3'd1,
      C_ALUR = 3'd2,
      C_ALUI = 3'd3,
      C_BR   = 3'd4
   } cls_t;

   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_ALUR = 7'b0110011;
   localparam logic [6:0] OP_ALUI = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [3:0] MEM_LAST = 4'(MEM_LATENCY - 1);

   state_t     state_q;
   cls_t       cls_q;
   logic       bne_q;     // funct3[0] of a branch: 1 = bne
   logic       f7_q;
   logic [3:0] cnt_q;     // remaining MEM cycles after the current one

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_INIT;
         cls_q   <= C_LD;
         bne_q   <= 1'b0;
         f7_q    <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            S_INIT: state_q <= S_FETCH;
            S_FETCH: begin
               if (run) state_q <= S_DECODE;
            end
            S_DECODE: begin
               bne_q   <= funct3[0];
               f7_q    <= funct7_5;
               state_q <= S_EXEC;
               case (opcode)
                  OP_LD: cls_q <= C_LD;
                  OP_ST: cls_q <= C_ST;
                  OP_ALUR: begin
                     cls_q <= C_ALUR;
                     if (funct3 != 3'b000) state_q <= S_HALT;
                  end
                  OP_ALUI: begin
                     cls_q <= C_ALUI;
                     if (funct3 != 3'b000) state_q <= S_HALT;
                  end
                  OP_BR: begin
                     cls_q <= C_BR;
                     if (funct3[2:1] != 2'b00) state_q <= S_HALT;
                  end
                  default: state_q <= S_HALT;
               endcase
            end
            S_EXEC: begin
               cnt_q <= MEM_LAST;
               case (cls_q)
                  C_LD, C_ST: state_q <= S_MEM;
                  C_BR:       state_q <= S_FETCH;
                  default:    state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (cnt_q == 4'd0) begin
                  state_q <= (cls_q == C_ST) ? S_FETCH : S_WB;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_WB:    state_q <= S_FETCH;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_INIT;
         endcase
      end
   end

   // ULA controls chosen in EXEC and held through MEM/WB
   logic din2_imm;
   logic sub_en;
   assign din2_imm = (cls_q == C_LD) || (cls_q == C_ST) || (cls_q == C_ALUI);
   assign sub_en   = (cls_q == C_BR) || ((cls_q == C_ALUR) && f7_q);

   always_comb begin
      load_ir      = 1'b0;
      load_pc      = 1'b0;
      reset_pc     = 1'b0;
      pc_next_sel  = 1'b0;
      sub          = 1'b0;
      ULA_din2_sel = 1'b0;
      RF_din_sel   = 1'b0;
      WE_RF        = 1'b0;
      WE_MEM       = 1'b0;
      halt         = 1'b0;
      case (state_q)
         S_INIT:  reset_pc = 1'b1;
         S_FETCH: load_ir  = run;
         S_EXEC: begin
            ULA_din2_sel = din2_imm;
            sub          = sub_en;
            if (cls_q == C_BR) begin
               load_pc     = 1'b1;
               pc_next_sel = bne_q ? ~zero : zero;
            end
         end
         S_MEM: begin
            ULA_din2_sel = 1'b1;
            if ((cls_q == C_ST) && (cnt_q == 4'd0)) begin
               WE_MEM  = 1'b1;
               load_pc = 1'b1;
            end
         end
         S_WB: begin
            ULA_din2_sel = din2_imm;
            sub          = sub_en;
            RF_din_sel   = (cls_q != C_LD);
            WE_RF        = 1'b1;
            load_pc      = 1'b1;
         end
         S_HALT:  halt = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state_q;

`ifdef CTRL_RETIRE_CNT_EN
   logic [CNT_W-1:0] retired_q;

   // load_pc is never high in HALT, so the count freezes there naturally
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         retired_q <= '0;
      end else if (load_pc) begin
         retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instance a uses MEM_LATENCY=1, instance b uses MEM_LATENCY=3.
module tb_multicycle_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       run = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;

   logic a_load_ir, a_load_pc, a_reset_pc, a_pc_next_sel, a_sub, a_din2, a_rfsel, a_WE_RF, a_WE_MEM, a_halt;
   logic b_load_ir, b_load_pc, b_reset_pc, b_pc_next_sel, b_sub, b_din2, b_rfsel, b_WE_RF, b_WE_MEM, b_halt;
   logic [2:0] a_state_o, b_state_o;
`ifdef CTRL_RETIRE_CNT_EN
   logic [15:0] a_retired_cnt, b_retired_cnt;
`endif

   int total = 0;
   int bad = 0;
   int wb_edges = 0;

   always #5 CLK = ~CLK;

   multicycle_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) dut_a (
      .CLK(CLK), .RESET_N(RESET_N), .run(run), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .load_ir(a_load_ir), .load_pc(a_load_pc),
      .reset_pc(a_reset_pc), .pc_next_sel(a_pc_next_sel), .sub(a_sub),
      .ULA_din2_sel(a_din2), .RF_din_sel(a_rfsel), .WE_RF(a_WE_RF), .WE_MEM(a_WE_MEM),
      .halt(a_halt),
`ifdef CTRL_RETIRE_CNT_EN
      .retired_cnt(a_retired_cnt),
`endif
      .state_o(a_state_o));

   multicycle_ctrl #(.MEM_LATENCY(3), .CNT_W(16)) dut_b (
      .CLK(CLK), .RESET_N(RESET_N), .run(run), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .load_ir(b_load_ir), .load_pc(b_load_pc),
      .reset_pc(b_reset_pc), .pc_next_sel(b_pc_next_sel), .sub(b_sub),
      .ULA_din2_sel(b_din2), .RF_din_sel(b_rfsel), .WE_RF(b_WE_RF), .WE_MEM(b_WE_MEM),
      .halt(b_halt),
`ifdef CTRL_RETIRE_CNT_EN
      .retired_cnt(b_retired_cnt),
`endif
      .state_o(b_state_o));

   // cycles in which instance a would write the register file at the closing edge
   always @(negedge CLK) if (a_WE_RF === 1'b1) wb_edges <= wb_edges + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      run = 1'b0;
      #1 RESET_N = 1'b0;
      @(posedge CLK);
      #2 RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      run = 1'b0;
      #1 RESET_N = 1'b0;
      #1;
      total++;
      if (a_state_o !== 3'd0 || a_reset_pc !== 1'b1 || a_halt !== 1'b0 || a_load_pc !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: state=%0d reset_pc=%b halt=%b load_pc=%b, want 0 1 0 0", a_state_o, a_reset_pc, a_halt, a_load_pc);
      end
      @(posedge CLK);
      #2 RESET_N = 1'b1;
      #1;
      total++;
      if (a_state_o !== 3'd0 || a_reset_pc !== 1'b1) begin
         bad++;
         $display("FAIL reset_init: state=%0d reset_pc=%b, want 0 1", a_state_o, a_reset_pc);
      end
      tick();
      total++;
      if (a_state_o !== 3'd1 || a_reset_pc !== 1'b0 || a_load_ir !== 1'b0) begin
         bad++;
         $display("FAIL reset_fetch: state=%0d reset_pc=%b load_ir=%b, want 1 0 0", a_state_o, a_reset_pc, a_load_ir);
      end
      tick();
      total++;
      if (a_state_o !== 3'd1 || a_load_ir !== 1'b0) begin
         bad++;
         $display("FAIL reset_park: state=%0d load_ir=%b, want 1 0", a_state_o, a_load_ir);
      end
      $display("txn reset: init then fetch parked");
   endtask

   task automatic test_ld();
      int exp_st[5] = '{2, 3, 4, 5, 1};
      int n = 0;
      bit got = 1'b0;
      opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0; run = 1'b1;
      #1;
      total++;
      if (a_state_o !== 3'd1 || a_load_ir !== 1'b1) begin
         bad++;
         $display("FAIL ld_fetch: state=%0d load_ir=%b, want 1 1", a_state_o, a_load_ir);
      end
      for (int i = 1; i <= 20 && !got; i++) begin
         tick();
         n = i;
         if (i <= 5) begin
            total++;
            if (a_state_o !== 3'(exp_st[i-1])) begin
               bad++;
               $display("FAIL ld_state%0d: state=%0d, want %0d", i, a_state_o, exp_st[i-1]);
            end
         end
         if (i == 3) begin
            total++;
            if (a_WE_MEM !== 1'b0 || a_load_pc !== 1'b0 || a_WE_RF !== 1'b0 || a_din2 !== 1'b1) begin
               bad++;
               $display("FAIL ld_mem: we_mem=%b load_pc=%b we_rf=%b din2=%b, want 0 0 0 1", a_WE_MEM, a_load_pc, a_WE_RF, a_din2);
            end
         end
         if (i == 4) begin
            total++;
            if (a_WE_RF !== 1'b1 || a_rfsel !== 1'b0 || a_din2 !== 1'b1 || a_load_pc !== 1'b1 ||
                a_pc_next_sel !== 1'b0 || a_WE_MEM !== 1'b0 || a_load_ir !== 1'b0) begin
               bad++;
               $display("FAIL ld_wb: we_rf=%b rf_sel=%b din2=%b load_pc=%b sel=%b we_mem=%b load_ir=%b, want 1 0 1 1 0 0 0",
                        a_WE_RF, a_rfsel, a_din2, a_load_pc, a_pc_next_sel, a_WE_MEM, a_load_ir);
            end
         end
         if (a_load_ir === 1'b1) got = 1'b1;
      end
      total++;
      if (!got || n != 5) begin
         bad++;
         $display("FAIL ld_spacing: next load_ir after %0d cycles (seen=%0d), want 5", n, got);
      end
      run = 1'b0;
      $display("txn ld: next load_ir after %0d cycles", n);
   endtask

   task automatic test_alu();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         logic f7;
         f7 = k[0];
         opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = f7; run = 1'b1;
         #1;
         total++;
         if (a_load_ir !== 1'b1 || a_state_o !== 3'd1) begin
            bad++;
            $display("FAIL alu%0d_fetch: state=%0d load_ir=%b, want 1 1", k, a_state_o, a_load_ir);
         end
         tick();
         tick();
         total++;
         if (a_state_o !== 3'd3 || a_din2 !== 1'b0 || a_sub !== f7 || a_WE_RF !== 1'b0 || a_load_pc !== 1'b0) begin
            bad++;
            $display("FAIL alu%0d_exec: state=%0d din2=%b sub=%b we_rf=%b load_pc=%b, want 3 0 %b 0 0",
                     k, a_state_o, a_din2, a_sub, a_WE_RF, a_load_pc, f7);
         end
         funct7_5 = ~f7;
         #1;
         total++;
         if (a_sub !== f7) begin
            bad++;
            $display("FAIL alu%0d_latch: sub=%b after funct7_5 change, want %b", k, a_sub, f7);
         end
         tick();
         total++;
         if (a_state_o !== 3'd5 || a_WE_RF !== 1'b1 || a_rfsel !== 1'b1 || a_din2 !== 1'b0 || a_sub !== f7 ||
             a_load_pc !== 1'b1 || a_pc_next_sel !== 1'b0 || a_WE_MEM !== 1'b0) begin
            bad++;
            $display("FAIL alu%0d_wb: state=%0d we_rf=%b rf_sel=%b din2=%b sub=%b load_pc=%b sel=%b we_mem=%b, want 5 1 1 0 %b 1 0 0",
                     k, a_state_o, a_WE_RF, a_rfsel, a_din2, a_sub, a_load_pc, a_pc_next_sel, a_WE_MEM, f7);
         end
         tick();
         total++;
         if (a_state_o !== 3'd1) begin
            bad++;
            $display("FAIL alu%0d_cycles: state=%0d after 4 cycles, want 1", k, a_state_o);
         end
         $display("txn %s: 4 cycles", k == 0 ? "add" : "sub");
      end
      run = 1'b0;
   endtask

   task automatic test_st();
      int exp_st[6] = '{1, 2, 3, 4, 4, 4};
      int pulses = 0;
      int pulse_idx = -1;
      int lp = 0;
      do_reset();
      opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; run = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         total++;
         if (b_state_o !== 3'(exp_st[i]) || b_WE_RF !== 1'b0) begin
            bad++;
            $display("FAIL st_cyc%0d: state=%0d we_rf=%b, want %0d 0", i, b_state_o, b_WE_RF, exp_st[i]);
         end
         if (b_load_pc === 1'b1) lp++;
         if (b_WE_MEM === 1'b1) begin
            pulses++;
            pulse_idx = i;
            total++;
            if (b_load_pc !== 1'b1 || b_pc_next_sel !== 1'b0) begin
               bad++;
               $display("FAIL st_pc: load_pc=%b sel=%b with we_mem, want 1 0", b_load_pc, b_pc_next_sel);
            end
         end
         if (i == 1) run = 1'b0;
      end
      total++;
      if (pulses != 1 || pulse_idx != 5 || lp != 1) begin
         bad++;
         $display("FAIL st_we_mem: pulses=%0d at cycle %0d load_pc pulses=%0d, want 1 5 1", pulses, pulse_idx, lp);
      end
      tick();
      total++;
      if (b_state_o !== 3'd1 || b_load_ir !== 1'b0 || b_WE_MEM !== 1'b0) begin
         bad++;
         $display("FAIL st_end: state=%0d load_ir=%b we_mem=%b, want 1 0 0", b_state_o, b_load_ir, b_WE_MEM);
      end
      $display("txn st: we_mem pulses=%0d at cycle %0d", pulses, pulse_idx);
   endtask

   task automatic test_branch();
      logic [2:0] f3v[4] = '{3'b001, 3'b001, 3'b000, 3'b000};
      logic       zv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic       ev[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         opcode = 7'b1100011; funct3 = f3v[k]; zero = zv[k]; run = 1'b1;
         #1;
         total++;
         if (a_load_ir !== 1'b1) begin
            bad++;
            $display("FAIL br%0d_fetch: load_ir=%b, want 1", k, a_load_ir);
         end
         tick();
         tick();
         funct3 = f3v[k] ^ 3'b001;
         #1;
         total++;
         if (a_state_o !== 3'd3 || a_load_pc !== 1'b1 || a_pc_next_sel !== ev[k] || a_sub !== 1'b1 ||
             a_din2 !== 1'b0 || a_WE_RF !== 1'b0 || a_WE_MEM !== 1'b0) begin
            bad++;
            $display("FAIL br%0d_exec: state=%0d load_pc=%b sel=%b sub=%b din2=%b we=%b%b, want 3 1 %b 1 0 00",
                     k, a_state_o, a_load_pc, a_pc_next_sel, a_sub, a_din2, a_WE_RF, a_WE_MEM, ev[k]);
         end
         zero = ~zv[k];
         #1;
         total++;
         if (a_pc_next_sel !== ~ev[k]) begin
            bad++;
            $display("FAIL br%0d_zero: sel=%b after zero flip, want %b", k, a_pc_next_sel, ~ev[k]);
         end
         tick();
         total++;
         if (a_state_o !== 3'd1) begin
            bad++;
            $display("FAIL br%0d_cycles: state=%0d after 3 cycles, want 1", k, a_state_o);
         end
         $display("txn %s zero=%b: pc_next_sel=%b", f3v[k][0] ? "bne" : "beq", zv[k], ev[k]);
      end
      run = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      opcode = 7'b1111111; funct3 = 3'b000; run = 1'b1;
      tick();
      total++;
      if (a_state_o !== 3'd2 || a_halt !== 1'b0) begin
         bad++;
         $display("FAIL halt_decode: state=%0d halt=%b, want 2 0", a_state_o, a_halt);
      end
      tick();
      total++;
      if (a_state_o !== 3'd6 || a_halt !== 1'b1 || a_load_pc !== 1'b0 || a_load_ir !== 1'b0 ||
          a_WE_RF !== 1'b0 || a_WE_MEM !== 1'b0 || a_reset_pc !== 1'b0) begin
         bad++;
         $display("FAIL halt_enter: state=%0d halt=%b lpc=%b lir=%b we=%b%b rpc=%b, want 6 1 0 0 00 0",
                  a_state_o, a_halt, a_load_pc, a_load_ir, a_WE_RF, a_WE_MEM, a_reset_pc);
      end
      run = 1'b0;
      tick();
      run = 1'b1;
      tick();
      total++;
      if (a_state_o !== 3'd6 || a_halt !== 1'b1 || a_load_ir !== 1'b0) begin
         bad++;
         $display("FAIL halt_sticky: state=%0d halt=%b load_ir=%b, want 6 1 0", a_state_o, a_halt, a_load_ir);
      end
      RESET_N = 1'b0;
      #1;
      total++;
      if (a_state_o !== 3'd0 || a_halt !== 1'b0 || a_reset_pc !== 1'b1) begin
         bad++;
         $display("FAIL halt_reset: state=%0d halt=%b reset_pc=%b, want 0 0 1", a_state_o, a_halt, a_reset_pc);
      end
      run = 1'b0;
      @(posedge CLK);
      #2 RESET_N = 1'b1;
      tick();
      total++;
      if (a_state_o !== 3'd1 || a_halt !== 1'b0) begin
         bad++;
         $display("FAIL halt_recover: state=%0d halt=%b, want 1 0", a_state_o, a_halt);
      end
      opcode = 7'b0110011; funct3 = 3'b001; run = 1'b1;
      tick();
      tick();
      total++;
      if (a_state_o !== 3'd6 || a_halt !== 1'b1) begin
         bad++;
         $display("FAIL halt_funct3: state=%0d halt=%b for ALU_R funct3=001, want 6 1", a_state_o, a_halt);
      end
      run = 1'b0;
      $display("txn illegal: halt sticky, cleared by reset");
   endtask

   task automatic test_reset_mid();
      int snap;
      int n;
      logic [6:0] ops[3] = '{7'b0000011, 7'b0000011, 7'b0110011};
      int cyc[3] = '{5, 5, 4};
      do_reset();
      opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1; run = 1'b1;
      tick();
      tick();
      total++;
      if (a_state_o !== 3'd3 || a_din2 !== 1'b1 || a_sub !== 1'b0) begin
         bad++;
         $display("FAIL addi_exec: state=%0d din2=%b sub=%b, want 3 1 0", a_state_o, a_din2, a_sub);
      end
      tick();
      total++;
      if (a_state_o !== 3'd5 || a_WE_RF !== 1'b1) begin
         bad++;
         $display("FAIL addi_wb: state=%0d we_rf=%b, want 5 1", a_state_o, a_WE_RF);
      end
      snap = wb_edges;
      #1 RESET_N = 1'b0;
      #1;
      total++;
      if (a_state_o !== 3'd0 || a_WE_RF !== 1'b0 || a_load_pc !== 1'b0 || a_reset_pc !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset: state=%0d we_rf=%b load_pc=%b reset_pc=%b, want 0 0 0 1",
                  a_state_o, a_WE_RF, a_load_pc, a_reset_pc);
      end
      run = 1'b0;
      funct7_5 = 1'b0;
      #2 RESET_N = 1'b1;
      tick();
      total++;
      if (a_state_o !== 3'd1 || wb_edges != snap) begin
         bad++;
         $display("FAIL mid_abort: state=%0d rf_write_cycles=%0d, want 1 %0d", a_state_o, wb_edges, snap);
      end
`ifdef CTRL_RETIRE_CNT_EN
      total++;
      if (a_retired_cnt !== 16'd0) begin
         bad++;
         $display("FAIL cnt_clear: retired_cnt=%0d, want 0", a_retired_cnt);
      end
`endif
      run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         opcode = ops[k];
         funct3 = (k < 2) ? 3'b010 : 3'b000;
         n = 0;
         do begin
            tick();
            n++;
            if (k == 2 && n == 1) run = 1'b0;
         end while (a_state_o !== 3'd1 && n < 20);
         total++;
         if (n != cyc[k]) begin
            bad++;
            $display("FAIL seq%0d_cycles: %0d cycles, want %0d", k, n, cyc[k]);
         end
      end
      total++;
      if (a_state_o !== 3'd1 || a_load_ir !== 1'b0 || wb_edges != snap + 3) begin
         bad++;
         $display("FAIL seq_end: state=%0d load_ir=%b rf_write_cycles=%0d, want 1 0 %0d",
                  a_state_o, a_load_ir, wb_edges, snap + 3);
      end
`ifdef CTRL_RETIRE_CNT_EN
      total++;
      if (a_retired_cnt !== 16'd3) begin
         bad++;
         $display("FAIL cnt_retired: retired_cnt=%0d, want 3", a_retired_cnt);
      end
`endif
      $display("txn ld,ld,add after aborted addi: rf_write_cycles=%0d", wb_edges - snap);
   endtask

   initial begin
      test_reset();
      test_ld();
      test_alu();
      test_st();
      test_branch();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
